// File: rtl/mem_wb_skid_reg_if.sv
// mem_wb_skid_reg_if: MEM->WB bundle handshake bus around the skid register.
// Upstream side : FlushW, ValidM/ReadyM, AluOutM, ReadDataM, WriteRegM, RegWriteM, MemToRegM
// Downstream side: ValidW/ReadyW, AluOutW, ReadDataW, WriteRegW, RegWriteW, MemToRegW, ResultW, CountW
// master drives the bundle and ReadyW; slave is the skid register itself.
interface mem_wb_skid_reg_if #(
   parameter int WIDTH  = 32,
   parameter int REG_AW = 5
);
   logic              MWBSKID_FlushW;
   logic              MWBSKID_ValidM;
   logic              MWBSKID_ReadyM;
   logic [WIDTH-1:0]  MWBSKID_AluOutM;
   logic [WIDTH-1:0]  MWBSKID_ReadDataM;
   logic [REG_AW-1:0] MWBSKID_WriteRegM;
   logic              MWBSKID_RegWriteM;
   logic              MWBSKID_MemToRegM;
   logic              MWBSKID_ValidW;
   logic              MWBSKID_ReadyW;
   logic [WIDTH-1:0]  MWBSKID_AluOutW;
   logic [WIDTH-1:0]  MWBSKID_ReadDataW;
   logic [REG_AW-1:0] MWBSKID_WriteRegW;
   logic              MWBSKID_RegWriteW;
   logic              MWBSKID_MemToRegW;
   logic [WIDTH-1:0]  MWBSKID_ResultW;
   logic [1:0]        MWBSKID_CountW;
   modport master (
      output MWBSKID_FlushW, MWBSKID_ValidM, MWBSKID_AluOutM, MWBSKID_ReadDataM,
             MWBSKID_WriteRegM, MWBSKID_RegWriteM, MWBSKID_MemToRegM, MWBSKID_ReadyW,
      input  MWBSKID_ReadyM, MWBSKID_ValidW, MWBSKID_AluOutW, MWBSKID_ReadDataW,
             MWBSKID_WriteRegW, MWBSKID_RegWriteW, MWBSKID_MemToRegW, MWBSKID_ResultW,
             MWBSKID_CountW
   );
   modport slave (
      input  MWBSKID_FlushW, MWBSKID_ValidM, MWBSKID_AluOutM, MWBSKID_ReadDataM,
             MWBSKID_WriteRegM, MWBSKID_RegWriteM, MWBSKID_MemToRegM, MWBSKID_ReadyW,
      output MWBSKID_ReadyM, MWBSKID_ValidW, MWBSKID_AluOutW, MWBSKID_ReadDataW,
             MWBSKID_WriteRegW, MWBSKID_RegWriteW, MWBSKID_MemToRegW, MWBSKID_ResultW,
             MWBSKID_CountW
   );
endinterface

// File: rtl/mem_wb_skid_reg.sv
// mem_wb_skid_reg: 2-entry skid buffer carrying the MEM result bundle into write-back.
// MWBSKID_CLK : rising-edge clock
// MWBSKID_RST : asynchronous active-low reset
// bus         : slave side of mem_wb_skid_reg_if (M-side bundle in, W-side head entry out)
module mem_wb_skid_reg #(
   parameter int WIDTH  = 32,
   parameter int REG_AW = 5
) (
   input logic              MWBSKID_CLK,
   input logic              MWBSKID_RST,
   mem_wb_skid_reg_if.slave bus
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
   typedef struct packed {
      logic [WIDTH-1:0]  alu;
      logic [WIDTH-1:0]  rd;
      logic [REG_AW-1:0] wr;
      logic              rw;
      logic              m2r;
   } bundle_t;
   state_t  state_q, state_d;
   bundle_t m_b, head_q, skid_q;
   logic    ready_q, in_hs, out_hs, ld_head_m, ld_head_skid, ld_skid;
   assign m_b    = {bus.MWBSKID_AluOutM, bus.MWBSKID_ReadDataM, bus.MWBSKID_WriteRegM,
                    bus.MWBSKID_RegWriteM, bus.MWBSKID_MemToRegM};
   assign in_hs  = bus.MWBSKID_ValidM & ready_q;
   assign out_hs = bus.MWBSKID_ValidW & bus.MWBSKID_ReadyW;
   always_comb begin
      state_d      = state_q;
      ld_head_m    = 1'b0;
      ld_head_skid = 1'b0;
      ld_skid      = 1'b0;
      case (state_q)
         EMPTY: if (in_hs) begin
            state_d   = ONE;
            ld_head_m = 1'b1;
         end
         ONE: begin
            state_d   = (in_hs & out_hs) ? ONE : out_hs ? EMPTY : in_hs ? TWO : ONE;
            ld_head_m = in_hs & out_hs;
            ld_skid   = in_hs & ~out_hs;
         end
         TWO: if (out_hs) begin
            state_d      = ONE;
            ld_head_skid = 1'b1;
         end
         default: state_d = EMPTY;
      endcase
      // Flush wins over any handshake; data registers are left untouched.
      if (bus.MWBSKID_FlushW) begin
         state_d      = EMPTY;
         ld_head_m    = 1'b0;
         ld_head_skid = 1'b0;
         ld_skid      = 1'b0;
      end
   end
   always_ff @(posedge MWBSKID_CLK or negedge MWBSKID_RST) begin
      if (!MWBSKID_RST) begin
         state_q <= EMPTY;
         ready_q <= 1'b1;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         // Registered ready: looks ahead at the next state so upstream never sees ReadyW combinationally.
         ready_q <= (state_d != TWO);
         if (ld_head_m) head_q <= m_b;
         else if (ld_head_skid) head_q <= skid_q;
         if (ld_skid) skid_q <= m_b;
      end
   end
   assign bus.MWBSKID_ReadyM    = ready_q;
   assign bus.MWBSKID_ValidW    = (state_q != EMPTY);
   assign bus.MWBSKID_AluOutW   = head_q.alu;
   assign bus.MWBSKID_ReadDataW = head_q.rd;
   assign bus.MWBSKID_WriteRegW = head_q.wr;
   assign bus.MWBSKID_RegWriteW = head_q.rw & (state_q != EMPTY);
   assign bus.MWBSKID_MemToRegW = head_q.m2r;
   assign bus.MWBSKID_ResultW   = head_q.m2r ? head_q.rd : head_q.alu;
   assign bus.MWBSKID_CountW    = (state_q == TWO) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;
endmodule

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
Parametrised successor to the fixed MEM->WB pipeline flip-flop. It carries the memory-stage result bundle into write-back through a 2-entry skid buffer with valid/ready handshakes on both sides, so variable-latency memory and a stallable write-back port are tolerated. It adds synchronous flush, a registered upstream ready, occupancy reporting and the final write-back result select. It sits between the data-memory stage and the register-file write port.

Parameters:
WIDTH, 32, data width of ALU result, read data and write-back result
REG_AW, 5, destination register address width

Ports:
MWBSKID_CLK  input  1  clock, rising edge
MWBSKID_RST  input  1  asynchronous active-low reset
MWBSKID_FlushW  input  1  synchronous flush, discards all held entries
MWBSKID_ValidM  input  1  upstream bundle valid
MWBSKID_ReadyM  output  1  upstream ready; registered, =1 unless both entries are full
MWBSKID_AluOutM  input  WIDTH  ALU result
MWBSKID_ReadDataM  input  WIDTH  memory read data
MWBSKID_WriteRegM  input  REG_AW  destination register
MWBSKID_RegWriteM  input  1  register write enable
MWBSKID_MemToRegM  input  1  result select, 1 = read data
MWBSKID_ValidW  output  1  head entry valid
MWBSKID_ReadyW  input  1  write-back accepts head entry
MWBSKID_AluOutW  output  WIDTH  head ALU result
MWBSKID_ReadDataW  output  WIDTH  head read data
MWBSKID_WriteRegW  output  REG_AW  head destination register
MWBSKID_RegWriteW  output  1  head RegWrite AND ValidW
MWBSKID_MemToRegW  output  1  head select
MWBSKID_ResultW  output  WIDTH  MemToRegW ? ReadDataW : AluOutW, combinational from head
MWBSKID_CountW  output  2  occupancy, 0..2

Behaviour:
- Storage: head register drives the W outputs; skid register is internal. State is EMPTY, ONE or TWO. CountW = 0/1/2 in those states.
- Handshakes: in = ValidM & ReadyM; out = ValidW & ReadyW. ValidW = (state != EMPTY). ReadyM = (state != TWO) and is a flop, not a function of ReadyW.
- EMPTY: in -> head <= M bundle, go to ONE. Otherwise hold.
- ONE: in & out -> head <= M bundle, stay in ONE. out only -> go to EMPTY. in only -> skid <= M bundle, go to TWO. Neither -> hold.
- TWO: no input is accepted. out -> head <= skid, go to ONE. Otherwise hold, with all W outputs stable.
- Order is preserved: the skid entry always leaves after the head entry.
- Latency: 1 cycle from in to ValidW when EMPTY. Sustained throughput is 1 bundle/cycle while ReadyW=1.
- Data fields change only on a load. When ValidW=0 they keep their last values, but RegWriteW is forced to 0.
- FlushW (priority over in/out): next state is EMPTY, ValidW=0, RegWriteW=0, CountW=0, ReadyM=1. A bundle presented in the flush cycle is discarded even if ReadyM=1. Data registers hold their values.
- Reset (asynchronous, any cycle, including mid-transfer): state EMPTY, ReadyM=1, ValidW=0, CountW=0. Head and skid fields all 0, so AluOutW, ReadDataW, ResultW, WriteRegW, RegWriteW and MemToRegW are 0. Normal operation resumes on the first clock edge after MWBSKID_RST is deasserted.
- ValidM with ReadyM=0: the bundle is not consumed, and upstream must hold it stable.
- ReadyW is not required to be stable; the head is accepted only on a cycle where ValidW & ReadyW.

Test Plan:
- Reset mid-stream: state TWO with heads 0x11/0x22, assert RST low -> immediately ValidW=0, ReadyM=1, CountW=0, ResultW=0x0, RegWriteW=0.
- Streaming: ReadyW=1, send AluOut 1,2,3,4 with RegWrite=1 on back-to-back cycles -> ValidW high from cycle 1, ResultW = 1,2,3,4 on consecutive cycles, CountW stays 1, ReadyM stays 1.
- Back-pressure: ReadyW=0, send A(Alu=0xA) then B(Alu=0xB) -> CountW=2, ReadyM=0, a held C is not taken. Raise ReadyW -> A, then B, then C emerge in order, and ReadyM returns to 1 one cycle after the first drain.
- Result select: MemToRegM=1, ReadDataM=0xDEADBEEF, AluOutM=0x5 -> ResultW=0xDEADBEEF. With MemToRegM=0 -> ResultW=0x5. WriteRegW=5'd17 is passed through.
- Flush: CountW=2 with ValidM=1 in the same cycle, pulse FlushW -> next cycle ValidW=0, RegWriteW=0, CountW=0, ReadyM=1. The flushed and presented bundles never appear at W.
- Simultaneous in/out in ONE: ReadyW=1, ValidM=1 -> CountW stays 1, head is replaced by the new bundle and the skid is never used.
